act_unit_arbiter: RTL

- Shares one pipelined hard-activation unit (hard tanh / hard sigmoid, Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH) between NUM_REQ requesters, e.g. the gate lanes of the recurrent denoise cell.
- Arbitrates round-robin and tags each result with the requester index and function.
- Sequences a 2-stage pipeline with output backpressure.

---
 rtl/act_unit_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/act_unit_arbiter.sv
// ============================================================================
// Module   : act_unit_arbiter
// Purpose  : Round-robin sharing of a 2-stage hard tanh / hard sigmoid unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module act_unit_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_func,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic                          out_func,
  output logic                          busy,
  output logic [15:0]                   op_count
);

  localparam int                           ONE_I     = 1 << FRACT_WIDTH;
  localparam logic signed [DATA_WIDTH:0]   ONE_E     = (DATA_WIDTH+1)'(ONE_I);
  localparam logic signed [DATA_WIDTH:0]   NEG_ONE_E = -ONE_E;
  localparam logic signed [DATA_WIDTH:0]   HALF_E    = (DATA_WIDTH+1)'(ONE_I / 2);
  localparam logic [DATA_WIDTH-1:0]        ONE_D     = DATA_WIDTH'(ONE_I);
  localparam logic [DATA_WIDTH-1:0]        NEG_ONE_D = -ONE_D;

  logic                   s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]  s1_data_q,  s1_data_d;
  logic                   s1_func_q,  s1_func_d;
  logic [ID_WIDTH-1:0]    s1_id_q,    s1_id_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q,  out_data_d;
  logic [ID_WIDTH-1:0]    out_id_q,    out_id_d;
  logic                   out_func_q,  out_func_d;
  logic [ID_WIDTH-1:0]    rr_ptr_q,    rr_ptr_d;
  logic [15:0]            op_count_q,  op_count_d;

  logic                   w_stall;
  logic                   w_grant_ok;
  logic                   w_hi_found, w_lo_found, w_any;
  logic [ID_WIDTH-1:0]    w_hi_idx, w_lo_idx, w_grant_idx;
  logic [NUM_REQ-1:0]     w_grant_oh;
  logic                   w_xfer;
  logic                   w_sel_func;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic signed [DATA_WIDTH:0] w_x_e, w_sig_e;
  logic [DATA_WIDTH-1:0]  w_result;

  assign w_stall    = out_valid_q & ~out_ready;
  assign w_grant_ok = ~w_stall | ~s1_valid_q;

  // Two passes split by the pointer: indices at/above rr_ptr win over wrapped ones.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (ID_WIDTH'(i) >= rr_ptr_q) begin
          if (!w_hi_found) begin
            w_hi_found = 1'b1;
            w_hi_idx   = ID_WIDTH'(i);
          end
        end else if (!w_lo_found) begin
          w_lo_found = 1'b1;
          w_lo_idx   = ID_WIDTH'(i);
        end
      end
    end
    w_any       = w_hi_found | w_lo_found;
    w_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_grant_oh = '0;
    w_sel_func = 1'b0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == ID_WIDTH'(i)) begin
        w_grant_oh[i] = ~rst & w_grant_ok & w_any;
        w_sel_func    = req_func[i];
        w_sel_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_xfer    = |w_grant_oh;
  assign req_ready = w_grant_oh;

  // One guard bit keeps the sigmoid shift-add from overflowing.
  assign w_x_e   = {s1_data_q[DATA_WIDTH-1], s1_data_q};
  assign w_sig_e = (w_x_e >>> 2) + HALF_E;

  always_comb begin
    w_result = s1_data_q;
    if (!s1_func_q) begin
      if (w_x_e > ONE_E)          w_result = ONE_D;
      else if (w_x_e < NEG_ONE_E) w_result = NEG_ONE_D;
    end else begin
      if (w_sig_e[DATA_WIDTH])    w_result = '0;
      else if (w_sig_e > ONE_E)   w_result = ONE_D;
      else                        w_result = w_sig_e[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_func_d   = s1_func_q;
    s1_id_d     = s1_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_func_d  = out_func_q;
    rr_ptr_d    = rr_ptr_q;
    op_count_d  = op_count_q;

    if (!w_stall) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = w_result;
        out_id_d   = s1_id_q;
        out_func_d = s1_func_q;
      end
      s1_valid_d = 1'b0;
    end

    if (w_xfer) begin
      s1_valid_d = 1'b1;
      s1_data_d  = w_sel_data;
      s1_func_d  = w_sel_func;
      s1_id_d    = w_grant_idx;
      rr_ptr_d   = (w_grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : w_grant_idx + ID_WIDTH'(1);
    end

    if (out_valid_q && out_ready && (op_count_q != 16'hFFFF))
      op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_func_q   <= 1'b0;
      s1_id_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_func_q  <= 1'b0;
      rr_ptr_q    <= '0;
      op_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_func_q   <= s1_func_d;
      s1_id_q     <= s1_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_func_q  <= out_func_d;
      rr_ptr_q    <= rr_ptr_d;
      op_count_q  <= op_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_func  = out_func_q;
  assign busy      = s1_valid_q | out_valid_q;
  assign op_count  = op_count_q;

endmodule

`default_nettype wire
